// File: rtl/mydesign_pipe_pkg.sv
// Shared defaults and helpers for the elastic pipeline harness around mydesign_comb.
package mydesign_pipe_pkg;

    localparam int DEF_N_IN       = 3;
    localparam int DEF_N_OUT      = 6;
    localparam int DEF_PIPE_DEPTH = 2;
    localparam int DEF_TAG_W      = 4;
    localparam int DEF_CNT_W      = 16;
    localparam int PIPE_DEPTH_MAX = 8;

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [63:0] sat_inc(input logic [63:0] cnt, input logic [63:0] max_val);
        return (cnt == max_val) ? cnt : cnt + 64'd1;
    endfunction

endpackage

// File: rtl/mydesign_comb.sv
// Generated combinational core: identity-encoded unsigned N_IN x N_IN multiplier.
module mydesign_comb #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 6
) (
    input  logic [N_IN-1:0]  a_i,
    input  logic [N_IN-1:0]  b_i,
    output logic [N_OUT-1:0] y_o
);

    assign y_o = N_OUT'(a_i) * N_OUT'(b_i);

endmodule

// File: rtl/mydesign_pipe_stage.sv
// One elastic register slice: accepts new data whenever empty or when its content leaves.
module mydesign_pipe_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk_ci,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign ready_o = ~valid_q | ready_i;

    // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned (no latch).
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ready_o) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so all stages sample the pre-edge values of their neighbours.
    // NOTE: the data register is reset too, because the last stage drives result_o/tag_o directly and they must read 0 in reset.
    always_ff @(posedge clk_ci or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/mydesign_pipe_top.sv
// Elastic harness: valid/ready input, PIPE_DEPTH output slices, tag sideband, optional perf counters.
// Counters are built only when MYDESIGN_PIPE_PERF_CNT_EN is defined; otherwise they read 0.
module mydesign_pipe_top
    import mydesign_pipe_pkg::*;
#(
    parameter int N_IN       = DEF_N_IN,
    parameter int N_OUT      = DEF_N_OUT,
    parameter int PIPE_DEPTH = DEF_PIPE_DEPTH,
    parameter int TAG_W      = DEF_TAG_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk_ci,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [N_IN-1:0]  operand_a_i,
    input  logic [N_IN-1:0]  operand_b_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [N_OUT-1:0] result_o,
    output logic [TAG_W-1:0] tag_o,
    input  logic             cnt_clr_i,
    output logic [CNT_W-1:0] ops_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int DATA_W = N_OUT + TAG_W;

    if (PIPE_DEPTH < 1 || PIPE_DEPTH > PIPE_DEPTH_MAX) begin : g_bad_depth
        $error("mydesign_pipe_top: PIPE_DEPTH must be in 1..%0d", PIPE_DEPTH_MAX);
    end
    if (N_OUT < N_IN) begin : g_bad_width
        $error("mydesign_pipe_top: N_OUT must be >= N_IN");
    end
    if (CNT_W < 1 || CNT_W > 64) begin : g_bad_cnt_w
        $error("mydesign_pipe_top: CNT_W must be in 1..64");
    end

    logic [N_OUT-1:0] core_result;

    (* dont_touch = "true" *)
    mydesign_comb #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_core (
        .a_i (operand_a_i),
        .b_i (operand_b_i),
        .y_o (core_result)
    );

    // Index k is the input of stage k; index PIPE_DEPTH is the block output.
    logic              stg_valid [PIPE_DEPTH+1];
    logic              stg_ready [PIPE_DEPTH+1];
    logic [DATA_W-1:0] stg_data  [PIPE_DEPTH+1];

    assign stg_valid[0]          = in_valid_i;
    assign stg_data[0]           = {core_result, tag_i};
    assign stg_ready[PIPE_DEPTH] = out_ready_i;
    assign in_ready_o            = stg_ready[0];

    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
        mydesign_pipe_stage #(
            .DATA_W (DATA_W)
        ) u_stage (
            .clk_ci  (clk_ci),
            .rst_i   (rst_i),
            .valid_i (stg_valid[k]),
            .ready_o (stg_ready[k]),
            .data_i  (stg_data[k]),
            .valid_o (stg_valid[k+1]),
            .ready_i (stg_ready[k+1]),
            .data_o  (stg_data[k+1])
        );
    end

    assign out_valid_o       = stg_valid[PIPE_DEPTH];
    assign {result_o, tag_o} = stg_data[PIPE_DEPTH];

`ifdef MYDESIGN_PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] ops_cnt_q, ops_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        ops_cnt_d   = ops_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr_i) begin
            ops_cnt_d   = '0;
            stall_cnt_d = '0;
        end else begin
            if (out_valid_o & out_ready_i) begin
                ops_cnt_d = CNT_W'(sat_inc(64'(ops_cnt_q), 64'(CNT_MAX)));
            end
            if (out_valid_o & ~out_ready_i) begin
                stall_cnt_d = CNT_W'(sat_inc(64'(stall_cnt_q), 64'(CNT_MAX)));
            end
        end
    end

    always_ff @(posedge clk_ci or posedge rst_i) begin
        if (rst_i) begin
            ops_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            ops_cnt_q   <= ops_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ops_cnt_o   = ops_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr_i;
    assign ops_cnt_o      = '0;
    assign stall_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_mydesign_pipe_top.sv
// Directed bench for mydesign_pipe_top with a 3x3 multiplier core, PIPE_DEPTH=2, TAG_W=4, CNT_W=4.
module tb_mydesign_pipe_top;

    logic       clk_ci = 1'b0;
    logic       rst_i;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [2:0] operand_a_i;
    logic [2:0] operand_b_i;
    logic [3:0] tag_i;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [5:0] result_o;
    logic [3:0] tag_o;
    logic       cnt_clr_i;
    logic [3:0] ops_cnt_o;
    logic [3:0] stall_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    mydesign_pipe_top #(
        .N_IN       (3),
        .N_OUT      (6),
        .PIPE_DEPTH (2),
        .TAG_W      (4),
        .CNT_W      (4)
    ) dut (
        .clk_ci      (clk_ci),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .tag_i       (tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .tag_o       (tag_o),
        .cnt_clr_i   (cnt_clr_i),
        .ops_cnt_o   (ops_cnt_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk_ci = ~clk_ci;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    // Registered outputs settle 2 time units after the edge; inputs change here too.
    task automatic tick();
        @(posedge clk_ci);
        #2;
    endtask

    task automatic drive(input logic v, input logic [2:0] a, input logic [2:0] b, input logic [3:0] t);
        in_valid_i  = v;
        operand_a_i = a;
        operand_b_i = b;
        tag_i       = t;
    endtask

    task automatic check_out(input string name, input logic v, input logic [5:0] r, input logic [3:0] t);
        check({name, "_valid"}, 32'(out_valid_o), 32'(v));
        if (v) begin
            check({name, "_result"}, 32'(result_o), 32'(r));
            check({name, "_tag"}, 32'(tag_o), 32'(t));
        end
    endtask

    task automatic check_cnt(input string name, input int ops, input int stall);
`ifdef MYDESIGN_PIPE_PERF_CNT_EN
        check({name, "_ops"}, 32'(ops_cnt_o), 32'(ops));
        check({name, "_stall"}, 32'(stall_cnt_o), 32'(stall));
`else
        check({name, "_ops"}, 32'(ops_cnt_o), 32'd0);
        check({name, "_stall"}, 32'(stall_cnt_o), 32'd0);
        if (ops < 0 || stall < 0) n_errors += 0;
`endif
    endtask

    initial begin
        rst_i       = 1'b1;
        out_ready_i = 1'b0;
        cnt_clr_i   = 1'b0;
        drive(1'b0, 3'd0, 3'd0, 4'd0);

        // Reset state
        #3;
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_result", 32'(result_o), 32'd0);
        check("rst_tag", 32'(tag_o), 32'd0);
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(in_ready_o), 32'd1);
        check_cnt("cnt_rst", 0, 0);

        // Single operation: 5*7 = 35, visible exactly two edges after the handshake
        out_ready_i = 1'b1;
        drive(1'b1, 3'd5, 3'd7, 4'd3);
        tick();
        drive(1'b0, 3'd0, 3'd0, 4'd0);
        #1;
        check_out("single_lat1", 1'b0, 6'd0, 4'd0);
        tick();
        #1;
        check_out("single_out", 1'b1, 6'd35, 4'd3);
        tick();
        #1;
        check_out("single_gone", 1'b0, 6'd0, 4'd0);

        // Streaming: a=i, b=7-i, tag=i, one per cycle
        for (int c = 0; c < 11; c++) begin
            if (c < 8) drive(1'b1, 3'(c), 3'(7 - c), 4'(c));
            else       drive(1'b0, 3'd0, 3'd0, 4'd0);
            #1;
            if (c < 8) check("stream_in_ready", 32'(in_ready_o), 32'd1);
            if (c >= 2 && c < 10) check_out("stream_out", 1'b1, 6'((c - 2) * (9 - c)), 4'(c - 2));
            else                  check_out("stream_idle", 1'b0, 6'd0, 4'd0);
            tick();
        end
        check_cnt("cnt_after_stream", 9, 0);

        cnt_clr_i = 1'b1;
        tick();
        cnt_clr_i = 1'b0;
        check_cnt("cnt_clr", 0, 0);

        // Backpressure: A=3*5, B=6*6, C=7*7 offered with out_ready low
        out_ready_i = 1'b0;
        drive(1'b1, 3'd3, 3'd5, 4'hA);
        #1;
        check("bp_accept_a", 32'(in_ready_o), 32'd1);
        tick();
        drive(1'b1, 3'd6, 3'd6, 4'hB);
        #1;
        check("bp_accept_b", 32'(in_ready_o), 32'd1);
        tick();
        drive(1'b1, 3'd7, 3'd7, 4'hC);
        for (int s = 0; s < 5; s++) begin
            #1;
            check("bp_in_ready", 32'(in_ready_o), 32'd0);
            check_out("bp_hold", 1'b1, 6'd15, 4'hA);
            tick();
        end

        // Release: full pipeline hands off and accepts C in the same cycle
        out_ready_i = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready_o), 32'd1);
        check_out("drain_a", 1'b1, 6'd15, 4'hA);
        check_cnt("cnt_stall", 0, 5);
        tick();
        drive(1'b1, 3'd2, 3'd3, 4'hD);
        #1;
        check("simul_in_ready", 32'(in_ready_o), 32'd1);
        check_out("drain_b", 1'b1, 6'd36, 4'hB);
        tick();
        drive(1'b0, 3'd0, 3'd0, 4'd0);
        #1;
        check_out("drain_c", 1'b1, 6'd49, 4'hC);
        tick();
        #1;
        check_out("drain_d", 1'b1, 6'd6, 4'hD);
        tick();
        #1;
        check_out("drain_empty", 1'b0, 6'd0, 4'd0);
        check_cnt("cnt_after_drain", 4, 5);

        // Reset with two operations in flight
        out_ready_i = 1'b0;
        drive(1'b1, 3'd1, 3'd1, 4'd1);
        tick();
        drive(1'b1, 3'd2, 3'd2, 4'd2);
        tick();
        drive(1'b0, 3'd0, 3'd0, 4'd0);
        #1;
        check_out("pre_rst", 1'b1, 6'd1, 4'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_async_valid", 32'(out_valid_o), 32'd0);
        check("rst_async_result", 32'(result_o), 32'd0);
        check("rst_async_tag", 32'(tag_o), 32'd0);
        check("rst_async_in_ready", 32'(in_ready_o), 32'd1);
        check_cnt("cnt_rst_async", 0, 0);
        tick();
        rst_i       = 1'b0;
        out_ready_i = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready_o), 32'd1);
        for (int s = 0; s < 3; s++) begin
            check("post_rst_no_stale", 32'(out_valid_o), 32'd0);
            tick();
        end

        // Counter saturation: 20 output handshakes into a 4-bit counter
        for (int c = 0; c < 22; c++) begin
            if (c < 20) drive(1'b1, 3'(c), 3'd1, 4'(c));
            else        drive(1'b0, 3'd0, 3'd0, 4'd0);
            #1;
            if (c >= 2) check_out("sat_stream", 1'b1, 6'((c - 2) % 8), 4'(c - 2));
            tick();
        end
        drive(1'b0, 3'd0, 3'd0, 4'd0);
        tick();
        check_cnt("cnt_sat", 15, 0);

        // Clear wins over a same-cycle increment
        drive(1'b1, 3'd5, 3'd5, 4'h5);
        tick();
        drive(1'b0, 3'd0, 3'd0, 4'd0);
        tick();
        cnt_clr_i = 1'b1;
        #1;
        check_out("clr_prio_out", 1'b1, 6'd25, 4'h5);
        tick();
        cnt_clr_i = 1'b0;
        #1;
        check_cnt("cnt_clr_prio", 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
